// File: rtl/cdc_bit_synchronizer.sv
// cdc_bit_synchronizer: multi-flop synchronizer for one asynchronous bit.
// Ports:
//   clk_i - destination clock
//   rst_i - asynchronous active-high reset, clears the chain to 0
//   d_i   - asynchronous input bit
//   q_o   - synchronized bit (last flop of the chain)
module cdc_bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    assign sync_d = {sync_q[STAGES-2:0], d_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/flag_toggle_transmitter.sv
// flag_toggle_transmitter: source end of a two-phase toggle flag crossing.
// Single-cycle flags are queued and sent as one REQ_TOGGLE edge each,
// each edge waiting for its ACK_TOGGLE echo before the next is issued.
// Ports:
//   CLK            - block clock
//   RESET          - asynchronous active-high reset
//   FLAG_IN        - one-cycle flag to transmit
//   CLEAR_ERR      - one-cycle clear of OVERFLOW and PROTOCOL_ERROR
//   ACK_TOGGLE     - far-domain echo of REQ_TOGGLE (asynchronous)
//   REQ_TOGGLE     - registered toggle, one edge per transmitted flag
//   BUSY           - waiting for an echo or flags still queued
//   PENDING        - flags queued and not yet issued
//   DONE           - one-cycle pulse per acknowledged flag
//   OVERFLOW       - sticky, a flag was dropped
//   PROTOCOL_ERROR - sticky, ACK moved with no request outstanding
module flag_toggle_transmitter #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 FLAG_IN,
    input  logic                 CLEAR_ERR,
    input  logic                 ACK_TOGGLE,
    output logic                 REQ_TOGGLE,
    output logic                 BUSY,
    output logic [CNT_WIDTH-1:0] PENDING,
    output logic                 DONE,
    output logic                 OVERFLOW,
    output logic                 PROTOCOL_ERROR
);

    localparam logic IDLE     = 1'b0;
    localparam logic WAIT_ACK = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic                 state_q;
    logic                 state_d;
    logic                 req_q;
    logic                 req_d;
    logic [CNT_WIDTH-1:0] pending_q;
    logic [CNT_WIDTH-1:0] pending_d;
    logic                 done_q;
    logic                 done_d;
    logic                 ovf_q;
    logic                 ovf_d;
    logic                 perr_q;
    logic                 perr_d;

    logic ack_s;
    logic match;
    logic pend_nz;
    logic issue;
    logic deq;
    logic enq;
    logic drop;
    logic perr_set;

    cdc_bit_synchronizer #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk_i(CLK),
        .rst_i(RESET),
        .d_i  (ACK_TOGGLE),
        .q_o  (ack_s)
    );

    assign match   = (ack_s == req_q);
    assign pend_nz = (pending_q != '0);

    // An issue draws from the queue when it holds anything, so a flag
    // arriving together with a non-empty queue is queued behind it.
    assign issue = (state_q == IDLE) && (FLAG_IN || pend_nz);
    assign deq   = issue && pend_nz;
    assign enq   = FLAG_IN && !(issue && !pend_nz);

    // A full queue still accepts a flag when a slot frees this cycle.
    assign drop = enq && (pending_q == CNT_MAX) && !deq;

    assign perr_set = (state_q == IDLE) && !issue && !match;

    // State register and datapath registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            pending_q <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            perr_q    <= perr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (match) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and counter logic
    always_comb begin
        req_d     = req_q ^ issue;
        done_d    = (state_q == WAIT_ACK) && match;
        pending_d = pending_q;
        unique case ({enq && !drop, deq})
            2'b10:   pending_d = pending_q + CNT_ONE;
            2'b01:   pending_d = pending_q - CNT_ONE;
            default: pending_d = pending_q;
        endcase
        // Set has priority over a same-cycle clear
        ovf_d  = drop || (ovf_q && !CLEAR_ERR);
        perr_d = perr_set || (perr_q && !CLEAR_ERR);
    end

    assign REQ_TOGGLE     = req_q;
    assign BUSY           = (state_q == WAIT_ACK) || pend_nz;
    assign PENDING        = pending_q;
    assign DONE           = done_q;
    assign OVERFLOW       = ovf_q;
    assign PROTOCOL_ERROR = perr_q;

endmodule

// File: tb/tb_flag_toggle_transmitter.sv
// Bench for flag_toggle_transmitter: far-side echo in an unrelated clock,
// transaction-level reference model, queue scoreboard and directed scenarios.
module tb_flag_toggle_transmitter;

    localparam int SS   = 2;
    localparam int CW   = 3;
    localparam int QMAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          FCLK = 1'b0;
    logic          RESET;
    logic          FLAG_IN;
    logic          CLEAR_ERR;
    logic          ACK_TOGGLE;
    logic          REQ_TOGGLE;
    logic          BUSY;
    logic [CW-1:0] PENDING;
    logic          DONE;
    logic          OVERFLOW;
    logic          PROTOCOL_ERROR;

    flag_toggle_transmitter #(
        .SYNC_STAGES(SS),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .FLAG_IN       (FLAG_IN),
        .CLEAR_ERR     (CLEAR_ERR),
        .ACK_TOGGLE    (ACK_TOGGLE),
        .REQ_TOGGLE    (REQ_TOGGLE),
        .BUSY          (BUSY),
        .PENDING       (PENDING),
        .DONE          (DONE),
        .OVERFLOW      (OVERFLOW),
        .PROTOCOL_ERROR(PROTOCOL_ERROR)
    );

    // CLK period 200, far clock period 274 (ratio 1.37)
    always #100 CLK = ~CLK;
    initial begin
        #37;
        forever #137 FCLK = ~FCLK;
    end

    int vectors = 0;
    int fails   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- far-side receiver/echo ----------------
    logic [2:0] far_q;
    int         delivered;
    logic       ack_hold;
    logic       ack_held;

    always @(posedge FCLK or posedge RESET) begin
        if (RESET) begin
            far_q     <= '0;
            delivered <= 0;
        end else begin
            far_q <= {far_q[1:0], REQ_TOGGLE};
            if (far_q[2] != far_q[1]) delivered <= delivered + 1;
        end
    end

    assign ACK_TOGGLE = ack_hold ? ack_held : far_q[2];

    // ---------------- reference model ----------------
    typedef struct {
        int c;
        bit l;
    } req_ev_t;

    int      cyc = 0;
    int      queued;
    int      issued;
    int      dropped;
    bit      outst;
    bit      req_par;
    bit      m_ovf;
    bit      m_perr;
    bit      hist[$];
    req_ev_t rq[$];
    int      dq[$];

    task model_reset();
        queued  = 0;
        issued  = 0;
        dropped = 0;
        outst   = 0;
        req_par = 0;
        m_ovf   = 0;
        m_perr  = 0;
        hist.delete();
        for (int i = 0; i < SS; i++) hist.push_back(1'b0);
        rq.delete();
        dq.delete();
    endtask

    initial begin
        bit ack_s;
        bit so;
        bit sp;
        req_ev_t ev;
        model_reset();
        forever begin
            @(posedge CLK or posedge RESET);
            if (RESET) begin
                model_reset();
            end else begin
                cyc++;
                // ACK as seen through SS flops
                ack_s = hist.pop_front();
                hist.push_back(ACK_TOGGLE);
                so = 0;
                sp = 0;
                if (FLAG_IN) issued++;
                if (!outst) begin
                    if (FLAG_IN || queued > 0) begin
                        if (queued > 0 && !FLAG_IN) queued--;
                        req_par = !req_par;
                        outst   = 1;
                        ev.c    = cyc;
                        ev.l    = req_par;
                        rq.push_back(ev);
                    end else if (ack_s != req_par) begin
                        sp = 1;
                    end
                end else begin
                    if (ack_s == req_par) begin
                        outst = 0;
                        dq.push_back(cyc);
                    end
                    if (FLAG_IN) begin
                        if (queued == QMAX) begin
                            dropped++;
                            so = 1;
                        end else begin
                            queued++;
                        end
                    end
                end
                m_ovf  = so || (m_ovf && !CLEAR_ERR);
                m_perr = sp || (m_perr && !CLEAR_ERR);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int req_seen  = 0;
    int done_seen = 0;

    initial begin
        bit req_prev;
        req_ev_t e;
        int d;
        req_prev = 0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                req_prev = 0;
            end else begin
                if (REQ_TOGGLE !== req_prev) begin
                    req_seen++;
                    if (rq.size() == 0) begin
                        chk("req_unexpected_edge", 1, 0);
                    end else begin
                        e = rq.pop_front();
                        chk("req_edge_cycle", cyc, e.c);
                        chk("req_edge_level", REQ_TOGGLE, e.l);
                    end
                    req_prev = REQ_TOGGLE;
                end
                while (rq.size() > 0 && rq[0].c < cyc) begin
                    chk("req_edge_missing", 0, 1);
                    void'(rq.pop_front());
                end
                if (DONE === 1'b1) begin
                    done_seen++;
                    if (dq.size() == 0) begin
                        chk("done_unexpected", 1, 0);
                    end else begin
                        d = dq.pop_front();
                        chk("done_cycle", cyc, d);
                    end
                end
                while (dq.size() > 0 && dq[0] < cyc) begin
                    chk("done_missing", 0, 1);
                    void'(dq.pop_front());
                end
                chk("pending", PENDING, queued);
                chk("busy", BUSY, (outst || queued != 0));
                chk("overflow", OVERFLOW, m_ovf);
                chk("protocol_error", PROTOCOL_ERROR, m_perr);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (BUSY && k < budget) begin
            tick();
            k++;
        end
        chk("idle_within_budget", BUSY, 0);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!DONE && k < budget) begin
            tick();
            k++;
        end
        chk("done_within_budget", DONE, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, REQ_TOGGLE, 0);
        chk({tag, "_pending"}, PENDING, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_overflow"}, OVERFLOW, 0);
        chk({tag, "_perr"}, PROTOCOL_ERROR, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int d0;
        int pmax;
        int dens;
        RESET     = 1'b0;
        FLAG_IN   = 1'b0;
        CLEAR_ERR = 1'b0;
        ack_hold  = 1'b0;
        ack_held  = 1'b0;
        #1 RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
        tick();
        chk_all_zero("reset");

        // 1: single flag
        tick(7);
        FLAG_IN = 1'b1;
        tick();
        FLAG_IN = 1'b0;
        chk("s1_req", REQ_TOGGLE, 1);
        chk("s1_busy", BUSY, 1);
        chk("s1_pending", PENDING, 0);
        wait_done(60);
        chk("s1_busy_at_done", BUSY, 0);
        tick();
        chk("s1_done_one_cycle", DONE, 0);

        // 2: burst of five
        tick(3);
        r0   = req_seen;
        d0   = done_seen;
        pmax = 0;
        for (int i = 0; i < 5; i++) begin
            FLAG_IN = 1'b1;
            tick();
            if (PENDING > pmax) pmax = PENDING;
        end
        FLAG_IN = 1'b0;
        chk("s2_pending_peak", pmax, 4);
        wait_idle(300);
        tick(2);
        chk("s2_req_edges", req_seen - r0, 5);
        chk("s2_done_pulses", done_seen - d0, 5);
        chk("s2_pending_final", PENDING, 0);
        chk("s2_overflow", OVERFLOW, 0);

        // 3: saturation with ACK held
        tick(2);
        ack_held = ACK_TOGGLE;
        ack_hold = 1'b1;
        r0       = req_seen;
        for (int i = 0; i < QMAX + 3; i++) begin
            FLAG_IN = 1'b1;
            tick();
        end
        FLAG_IN = 1'b0;
        chk("s3_pending_full", PENDING, QMAX);
        chk("s3_overflow", OVERFLOW, 1);
        tick(5);
        chk("s3_pending_held", PENDING, QMAX);
        ack_hold = 1'b0;
        wait_idle(600);
        tick(2);
        chk("s3_req_edges", req_seen - r0, QMAX + 1);
        chk("s3_overflow_sticky", OVERFLOW, 1);
        CLEAR_ERR = 1'b1;
        tick();
        CLEAR_ERR = 1'b0;
        chk("s3_overflow_cleared", OVERFLOW, 0);

        // 4: spurious ACK edge while idle
        tick(3);
        ack_held = ACK_TOGGLE;
        ack_hold = 1'b1;
        tick();
        ack_held = ~ack_held;
        tick(SS + 2);
        chk("s4_perr", PROTOCOL_ERROR, 1);
        chk("s4_req_unchanged", REQ_TOGGLE, req_par);
        CLEAR_ERR = 1'b1;
        tick();
        CLEAR_ERR = 1'b0;
        chk("s4_set_beats_clear", PROTOCOL_ERROR, 1);
        ack_hold = 1'b0;
        tick(SS + 2);
        CLEAR_ERR = 1'b1;
        tick();
        CLEAR_ERR = 1'b0;
        chk("s4_perr_cleared", PROTOCOL_ERROR, 0);

        // 5: reset in WAIT_ACK with two queued
        tick(2);
        ack_held = ACK_TOGGLE;
        ack_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            FLAG_IN = 1'b1;
            tick();
        end
        FLAG_IN = 1'b0;
        chk("s5_pending_pre", PENDING, 2);
        chk("s5_busy_pre", BUSY, 1);
        chk("s5_req_pre", REQ_TOGGLE, 1);
        #20 RESET = 1'b1;
        ack_hold = 1'b0;
        #10;
        chk_all_zero("s5_async");
        tick(2);
        RESET = 1'b0;
        tick(2);
        FLAG_IN = 1'b1;
        tick();
        FLAG_IN = 1'b0;
        chk("s5_req_after", REQ_TOGGLE, 1);
        chk("s5_pending_after", PENDING, 0);
        wait_done(60);
        tick(2);

        // 6: random density
        for (int seg = 0; seg < 8; seg++) begin
            dens = (seg == 0) ? 100 : (seg == 1) ? 0
                 : int'($urandom_range(0, 100));
            for (int c = 0; c < 500; c++) begin
                FLAG_IN = ($urandom_range(0, 99) < dens);
                tick();
            end
        end
        FLAG_IN = 1'b0;
        wait_idle(2000);
        tick(10);
        chk("s6_conservation", delivered + dropped, issued);
        chk("s6_overflow_iff_drop", OVERFLOW, (dropped > 0));
        chk("s6_req_queue_drained", rq.size(), 0);
        chk("s6_done_queue_drained", dq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, fails);
        $finish;
    end

endmodule
